uart_prog_loader: RTL and testbench
===================================

// Module: uart_prog_loader
// PURPOSE
//   Sequences program download and CPU run control over the byte-level UART.
//   Parses ASCII hex from the UART receiver into 32-bit words, writes them to instruction memory,
//   echoes every accepted byte, and gates the pipelined CPU's run/start line.
//   Sits between the uart RX/TX byte handshake and the CPU's instr_mem write port / start input.
// PARAMETERS
//   ADDR_W   4    instruction memory address width; DEPTH = 2**ADDR_W words
//   WORD_W   32   instruction word width; NIBS = WORD_W/4 hex chars per word
// PORTS
//   clk          in   1         system clock, all logic on rising edge
//   rst          in   1         asynchronous, active-high reset
//   rx_rdy       in   1         UART RX byte available
//   rx_data      in   8         UART RX byte
//   rx_rdy_clr   out  1         1-cycle pulse: consume RX byte
//   tx_busy      in   1         UART TX busy
//   tx_wr_en     out  1         1-cycle pulse: send tx_data
//   tx_data      out  8         response byte
//   imem_we      out  1         1-cycle instruction memory write strobe
//   imem_addr    out  ADDR_W    word address for write
//   imem_wdata   out  WORD_W    assembled word
//   cpu_run      out  1         level: CPU start/enable
//   cpu_halted   in   1         level: CPU executed ebreak
//   words_loaded out  ADDR_W+1  words written since last 'L' (0..DEPTH)
//   err          out  1         sticky: bad char, overflow or partial word discarded
// BEHAVIOUR
//   Reset (async, rst=1): every output 0; state IDLE; addr, nibble count, shift reg, pending-tx cleared.
//     Reset mid-write or mid-run drops imem_we/cpu_run immediately.
//   Accept: byte accepted in cycle N iff rx_rdy & !tx_busy & !tx_pending & !halt_event.
//     rx_rdy_clr=1 in N+1, exactly one pulse per byte.
//   Response: each accepted byte yields exactly one TX byte:
//     echo of the byte if legal; '?'(0x3F) if illegal in the current state; '!'(0x21) on overflow.
//     tx_wr_en pulses in N+1 if tx_busy=0, else the byte is held in tx_pending and sent on the
//     first cycle tx_busy=0. tx_data is stable while tx_wr_en=1.
//   Hex chars: 0x30-0x39, 0x41-0x46, 0x61-0x66 map to nibbles 0-F; all other bytes are non-hex.
//   States:
//     IDLE:
//       'L'(0x4C) -> LOAD; clears addr, words_loaded, nibble count, shift reg, err.
//       'G'(0x47) -> RUN if words_loaded>0, else '?' and err=1.
//       Any other byte -> '?', err=1.
//     LOAD:
//       Hex char shifts in MSB-first (shift = {shift[WORD_W-5:0], nib}); nibble count +1.
//       On the NIBS-th nibble: imem_we=1 in N+1 with imem_addr=addr and imem_wdata=completed word;
//       then addr+1, words_loaded+1, nibble count 0.
//       If words_loaded==DEPTH: hex -> '!', err=1, nothing written; addr never wraps.
//       '.'(0x2E) -> IDLE; a nonzero nibble count is discarded and sets err.
//       Other bytes -> '?', err=1, no state change.
//     RUN:
//       cpu_run=1 from the cycle after 'G' is accepted.
//       'X'(0x58) -> IDLE, cpu_run=0 next cycle.
//       Other bytes -> '?'.
//       Rising edge of cpu_halted (halt_event) -> send 'H'(0x48), cpu_run=0, -> IDLE.
//   Simultaneous: halt_event has priority; an RX byte in the same cycle is not accepted
//     (rx_rdy stays high) and is taken on a later cycle.
//   imem_we never asserts outside LOAD; cpu_run never asserts outside RUN.
// STRUCTURE
//   Package uart_loader_pkg: state enum {IDLE,LOAD,RUN}; ASCII constants
//     CH_L, CH_G, CH_X, CH_DOT, CH_Q, CH_BANG, CH_H.
//   Sub-module hex_ascii_decode (combinational): byte -> {is_hex, nib[3:0]}.
//   Top: FSM, shift reg, nibble/addr counters, tx_pending register.
// TESTING
//   1. 'L' then "00500093": 8 echoes; imem_we once, addr 0, wdata 32'h00500093; words_loaded=1.
//   2. tx_busy held 1 for 100 cycles while rx_rdy=1: no rx_rdy_clr, no tx_wr_en; on release,
//      one accept and one echo.
//   3. Load 16 words, then "1": response '!', err=1, no imem_we, words_loaded=16.
//   4. 'L', "12Z", '.': 'Z' -> '?'; '.' echoed, err=1, no write, state IDLE.
//   5. 'G' after 1 word -> cpu_run=1; cpu_halted 0->1 with rx_rdy=1 same cycle: 'H' sent first,
//      cpu_run=0, then byte accepted.
//   6. Reset asserted in the cycle imem_we is high and while cpu_run=1:
//      outputs 0 asynchronously; after release 'G' -> '?' (words_loaded=0).

Source files
------------

// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared state encoding and ASCII protocol constants for the UART program loader
package uart_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [7:0] CH_L    = 8'h4C;
    localparam logic [7:0] CH_G    = 8'h47;
    localparam logic [7:0] CH_X    = 8'h58;
    localparam logic [7:0] CH_DOT  = 8'h2E;
    localparam logic [7:0] CH_Q    = 8'h3F;
    localparam logic [7:0] CH_BANG = 8'h21;
    localparam logic [7:0] CH_H    = 8'h48;

endpackage

// File: rtl/hex_ascii_decode.sv
// rtl/hex_ascii_decode.sv - combinational ASCII hex character to nibble decoder
module hex_ascii_decode (
    input  logic [7:0] i_byte,
    output logic       o_is_hex,
    output logic [3:0] o_nib
);

    always_comb begin
        o_is_hex = 1'b0;
        o_nib    = 4'h0;
        if (i_byte >= 8'h30 && i_byte <= 8'h39) begin
            o_is_hex = 1'b1;
            o_nib    = i_byte[3:0];
        end else if ((i_byte >= 8'h41 && i_byte <= 8'h46) ||
                     (i_byte >= 8'h61 && i_byte <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 lands on 0xA
            o_is_hex = 1'b1;
            o_nib    = i_byte[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART hex program loader: parses words into instruction memory and gates CPU run
module uart_prog_loader
    import uart_loader_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int WORD_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx_rdy,
    input  logic [7:0]        i_rx_data,
    output logic              o_rx_rdy_clr,
    input  logic              i_tx_busy,
    output logic              o_tx_wr_en,
    output logic [7:0]        o_tx_data,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [WORD_W-1:0] o_imem_wdata,
    output logic              o_cpu_run,
    input  logic              i_cpu_halted,
    output logic [ADDR_W:0]   o_words_loaded,
    output logic              o_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NIBS  = WORD_W / 4;
    localparam int NC_W  = $clog2(NIBS);

    state_t            r_state;
    logic [WORD_W-1:0] r_shift;
    logic [NC_W-1:0]   r_nib_cnt;
    logic [ADDR_W:0]   r_words;
    logic              r_tx_pending;
    logic [7:0]        r_tx_pend_data;
    logic              r_halted_d;
    logic              r_halt_req;
    logic              r_rx_rdy_clr;
    logic              r_tx_wr_en;
    logic [7:0]        r_tx_data;
    logic              r_imem_we;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [WORD_W-1:0] r_imem_wdata;
    logic              r_cpu_run;
    logic              r_err;

    logic              w_is_hex;
    logic [3:0]        w_nib;
    logic [WORD_W-1:0] w_shift_nxt;
    logic              w_halt_evt;
    logic              w_halt_now;
    logic              w_accept;
    logic              w_full;
    logic              w_nib_last;

    hex_ascii_decode u_hex (
        .i_byte   (i_rx_data),
        .o_is_hex (w_is_hex),
        .o_nib    (w_nib)
    );

    assign w_shift_nxt = {r_shift[WORD_W-5:0], w_nib};
    assign w_halt_evt  = i_cpu_halted & ~r_halted_d;
    assign w_halt_now  = (r_state == RUN) & (w_halt_evt | r_halt_req);
    assign w_full      = (r_words == (ADDR_W+1)'(DEPTH));
    assign w_nib_last  = (r_nib_cnt == NC_W'(NIBS-1));
    // Blocking the cycle after an accept/send keeps a still-high rx_rdy or a lagging tx_busy from double-firing
    assign w_accept    = i_rx_rdy & ~i_tx_busy & ~r_tx_pending & ~w_halt_evt & ~w_halt_now
                       & ~r_rx_rdy_clr & ~r_tx_wr_en;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= IDLE;
            r_shift        <= '0;
            r_nib_cnt      <= '0;
            r_words        <= '0;
            r_tx_pending   <= 1'b0;
            r_tx_pend_data <= '0;
            r_halted_d     <= 1'b0;
            r_halt_req     <= 1'b0;
            r_rx_rdy_clr   <= 1'b0;
            r_tx_wr_en     <= 1'b0;
            r_tx_data      <= '0;
            r_imem_we      <= 1'b0;
            r_imem_addr    <= '0;
            r_imem_wdata   <= '0;
            r_cpu_run      <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_rx_rdy_clr <= 1'b0;
            r_tx_wr_en   <= 1'b0;
            r_imem_we    <= 1'b0;
            r_halted_d   <= i_cpu_halted;
            if (w_halt_evt && r_state == RUN)
                r_halt_req <= 1'b1;

            if (r_tx_pending && !i_tx_busy && !r_tx_wr_en) begin
                r_tx_wr_en   <= 1'b1;
                r_tx_data    <= r_tx_pend_data;
                r_tx_pending <= 1'b0;
            end else if (w_halt_now) begin
                r_halt_req <= 1'b0;
                r_cpu_run  <= 1'b0;
                r_state    <= IDLE;
                if (!i_tx_busy && !r_tx_wr_en) begin
                    r_tx_wr_en <= 1'b1;
                    r_tx_data  <= CH_H;
                end else begin
                    r_tx_pending   <= 1'b1;
                    r_tx_pend_data <= CH_H;
                end
            end else if (w_accept) begin
                r_rx_rdy_clr <= 1'b1;
                r_tx_wr_en   <= 1'b1;
                r_tx_data    <= i_rx_data;
                case (r_state)
                    IDLE: begin
                        if (i_rx_data == CH_L) begin
                            r_state   <= LOAD;
                            r_words   <= '0;
                            r_nib_cnt <= '0;
                            r_shift   <= '0;
                            r_err     <= 1'b0;
                        end else if (i_rx_data == CH_G && r_words != '0) begin
                            r_state   <= RUN;
                            r_cpu_run <= 1'b1;
                        end else begin
                            r_tx_data <= CH_Q;
                            r_err     <= 1'b1;
                        end
                    end
                    LOAD: begin
                        if (w_is_hex) begin
                            if (w_full) begin
                                r_tx_data <= CH_BANG;
                                r_err     <= 1'b1;
                            end else begin
                                r_shift <= w_shift_nxt;
                                if (w_nib_last) begin
                                    r_imem_we    <= 1'b1;
                                    r_imem_addr  <= r_words[ADDR_W-1:0];
                                    r_imem_wdata <= w_shift_nxt;
                                    r_words      <= r_words + 1'b1;
                                    r_nib_cnt    <= '0;
                                end else begin
                                    r_nib_cnt <= r_nib_cnt + 1'b1;
                                end
                            end
                        end else if (i_rx_data == CH_DOT) begin
                            r_state   <= IDLE;
                            r_nib_cnt <= '0;
                            r_shift   <= '0;
                            if (r_nib_cnt != '0)
                                r_err <= 1'b1;
                        end else begin
                            r_tx_data <= CH_Q;
                            r_err     <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (i_rx_data == CH_X) begin
                            r_state   <= IDLE;
                            r_cpu_run <= 1'b0;
                        end else begin
                            r_tx_data <= CH_Q;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_rx_rdy_clr   = r_rx_rdy_clr;
    assign o_tx_wr_en     = r_tx_wr_en;
    assign o_tx_data      = r_tx_data;
    assign o_imem_we      = r_imem_we;
    assign o_imem_addr    = r_imem_addr;
    assign o_imem_wdata   = r_imem_wdata;
    assign o_cpu_run      = r_cpu_run;
    assign o_words_loaded = r_words;
    assign o_err          = r_err;

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - self-checking bench for uart_prog_loader
module tb_uart_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_rdy_clr;
    logic        tx_busy = 1'b0;
    logic        tx_wr_en;
    logic [7:0]  tx_data;
    logic        imem_we;
    logic [3:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_run;
    logic        cpu_halted = 1'b0;
    logic [4:0]  words_loaded;
    logic        err;

    uart_prog_loader #(.ADDR_W(4), .WORD_W(32)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_rx_rdy       (rx_rdy),
        .i_rx_data      (rx_data),
        .o_rx_rdy_clr   (rx_rdy_clr),
        .i_tx_busy      (tx_busy),
        .o_tx_wr_en     (tx_wr_en),
        .o_tx_data      (tx_data),
        .o_imem_we      (imem_we),
        .o_imem_addr    (imem_addr),
        .o_imem_wdata   (imem_wdata),
        .o_cpu_run      (cpu_run),
        .i_cpu_halted   (cpu_halted),
        .o_words_loaded (words_loaded),
        .o_err          (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  txq[$];
    logic [3:0]  wea[$];
    logic [31:0] wed[$];
    int          clr_cnt = 0;

    always @(negedge clk) begin
        if (tx_wr_en) txq.push_back(tx_data);
        if (imem_we) begin
            wea.push_back(imem_addr);
            wed.push_back(imem_wdata);
        end
        if (rx_rdy_clr) clr_cnt++;
    end

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_tx;
        int         exp_we;
        logic       exp_err;
        logic [4:0] exp_words;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] txat(input int i);
        return (i < txq.size()) ? txq[i] : 8'h00;
    endfunction

    function automatic logic [7:0] hexc(input int v);
        return (v < 10) ? 8'(8'h30 + v) : 8'(8'h41 + v - 10);
    endfunction

    task automatic add(input logic [7:0] d, input logic [7:0] t, input int we,
                       input logic e, input logic [4:0] w);
        vec_t v;
        v.din = d; v.exp_tx = t; v.exp_we = we; v.exp_err = e; v.exp_words = w;
        vecs.push_back(v);
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        @(negedge clk);
        rx_rdy  = 1'b1;
        rx_data = b;
        n = 0;
        while (!rx_rdy_clr && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rx_accept", 64'(rx_rdy_clr), 64'd1);
        rx_rdy = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    initial begin
        int n;
        int c0;
        int t0;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {rx_rdy_clr, tx_wr_en, tx_data, imem_we, imem_addr, imem_wdata,
                              cpu_run, words_loaded, err}, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        add("G", 8'h3F, 0, 1'b1, 5'd0);
        add("L", "L",   0, 1'b0, 5'd0);
        add("0", "0", 0, 1'b0, 5'd0); add("0", "0", 0, 1'b0, 5'd0);
        add("5", "5", 0, 1'b0, 5'd0); add("0", "0", 0, 1'b0, 5'd0);
        add("0", "0", 0, 1'b0, 5'd0); add("0", "0", 0, 1'b0, 5'd0);
        add("9", "9", 0, 1'b0, 5'd0); add("3", "3", 1, 1'b0, 5'd1);
        add("d", "d", 0, 1'b0, 5'd1); add("e", "e", 0, 1'b0, 5'd1);
        add("a", "a", 0, 1'b0, 5'd1); add("d", "d", 0, 1'b0, 5'd1);
        add("B", "B", 0, 1'b0, 5'd1); add("E", "E", 0, 1'b0, 5'd1);
        add("E", "E", 0, 1'b0, 5'd1); add("F", "F", 1, 1'b0, 5'd2);
        add(".", ".",   0, 1'b0, 5'd2);
        add("Q", 8'h3F, 0, 1'b1, 5'd2);
        add("L", "L",   0, 1'b0, 5'd0);
        add("1", "1",   0, 1'b0, 5'd0);
        add("2", "2",   0, 1'b0, 5'd0);
        add("Z", 8'h3F, 0, 1'b1, 5'd0);
        add(".", ".",   0, 1'b1, 5'd0);
        add("G", 8'h3F, 0, 1'b1, 5'd0);

        wea.delete(); wed.delete();
        for (int i = 0; i < vecs.size(); i++) begin
            int we0;
            txq.delete();
            we0 = wea.size();
            send(vecs[i].din);
            chk($sformatf("v%0d_txcnt", i), 64'(txq.size()), 64'd1);
            chk($sformatf("v%0d_tx", i), 64'(txat(0)), 64'(vecs[i].exp_tx));
            chk($sformatf("v%0d_we", i), 64'(wea.size() - we0), 64'(vecs[i].exp_we));
            chk($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
            chk($sformatf("v%0d_words", i), 64'(words_loaded), 64'(vecs[i].exp_words));
        end
        chk("w0_addr", 64'(wea.size() > 0 ? wea[0] : 4'hF), 64'd0);
        chk("w0_data", 64'(wed.size() > 0 ? wed[0] : 32'h0), 64'h00500093);
        chk("w1_addr", 64'(wea.size() > 1 ? wea[1] : 4'hF), 64'd1);
        chk("w1_data", 64'(wed.size() > 1 ? wed[1] : 32'h0), 64'hDEADBEEF);

        // tx_busy stall: nothing consumed or sent until the transmitter frees up
        txq.delete();
        c0 = clr_cnt;
        @(negedge clk);
        tx_busy = 1'b1;
        rx_rdy  = 1'b1;
        rx_data = "L";
        repeat (100) @(negedge clk);
        chk("busy_no_clr", 64'(clr_cnt - c0), 64'd0);
        chk("busy_no_tx", 64'(txq.size()), 64'd0);
        tx_busy = 1'b0;
        n = 0;
        while (!rx_rdy_clr && n < 50) begin
            @(negedge clk);
            n++;
        end
        rx_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_one_clr", 64'(clr_cnt - c0), 64'd1);
        chk("busy_one_tx", 64'(txq.size()), 64'd1);
        chk("busy_echo", 64'(txat(0)), 64'("L"));

        // fill all 16 words, word k = k
        wea.delete(); wed.delete(); txq.delete();
        for (int k = 0; k < 16; k++) begin
            send_str("0000000");
            send(hexc(k));
        end
        chk("fill_txcnt", 64'(txq.size()), 64'd128);
        chk("fill_wecnt", 64'(wea.size()), 64'd16);
        for (int k = 0; k < 16 && k < wea.size(); k++) begin
            chk($sformatf("fill_addr%0d", k), 64'(wea[k]), 64'(k));
            chk($sformatf("fill_data%0d", k), 64'(wed[k]), 64'(k));
        end
        chk("fill_words", 64'(words_loaded), 64'd16);
        chk("fill_err", 64'(err), 64'd0);

        wea.delete(); txq.delete();
        send("1");
        chk("ovf_tx", 64'(txat(0)), 64'h21);
        chk("ovf_err", 64'(err), 64'd1);
        chk("ovf_no_we", 64'(wea.size()), 64'd0);
        chk("ovf_words", 64'(words_loaded), 64'd16);
        send(".");
        chk("ovf_err_sticky", 64'(err), 64'd1);

        // run, then halt racing an incoming byte
        txq.delete();
        send("G");
        chk("run_echo", 64'(txat(0)), 64'("G"));
        chk("run_on", 64'(cpu_run), 64'd1);
        txq.delete();
        send("A");
        chk("run_q", 64'(txat(0)), 64'h3F);
        chk("run_still", 64'(cpu_run), 64'd1);

        txq.delete();
        c0 = clr_cnt;
        @(negedge clk);
        cpu_halted = 1'b1;
        rx_rdy     = 1'b1;
        rx_data    = "X";
        @(negedge clk);
        chk("halt_tx_en", 64'(tx_wr_en), 64'd1);
        chk("halt_tx_h", 64'(tx_data), 64'h48);
        chk("halt_no_clr", 64'(rx_rdy_clr), 64'd0);
        chk("halt_run_off", 64'(cpu_run), 64'd0);
        n = 0;
        while (!rx_rdy_clr && n < 50) begin
            @(negedge clk);
            n++;
        end
        rx_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("halt_clr_cnt", 64'(clr_cnt - c0), 64'd1);
        chk("halt_txcnt", 64'(txq.size()), 64'd2);
        chk("halt_first", 64'(txat(0)), 64'h48);
        chk("halt_then_q", 64'(txat(1)), 64'h3F);
        chk("halt_run_low", 64'(cpu_run), 64'd0);
        cpu_halted = 1'b0;
        repeat (2) @(negedge clk);

        txq.delete();
        send("G");
        chk("rerun_on", 64'(cpu_run), 64'd1);
        send("X");
        chk("x_echo", 64'(txat(1)), 64'("X"));
        chk("x_run_off", 64'(cpu_run), 64'd0);

        // reset while running
        send("G");
        chk("pre_rst_run", 64'(cpu_run), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_run_async", {rx_rdy_clr, tx_wr_en, tx_data, imem_we, imem_addr, imem_wdata,
                              cpu_run, words_loaded, err}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // reset landing in the imem write cycle
        send("L");
        send_str("0000000");
        @(negedge clk);
        rx_rdy  = 1'b1;
        rx_data = "7";
        n = 0;
        while (!imem_we && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("we_seen", 64'(imem_we), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_we_async", {rx_rdy_clr, tx_wr_en, tx_data, imem_we, imem_addr, imem_wdata,
                             cpu_run, words_loaded, err}, 64'd0);
        rx_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        txq.delete();
        t0 = 0;
        send("G");
        chk("post_rst_g", 64'(txat(t0)), 64'h3F);
        chk("post_rst_words", 64'(words_loaded), 64'd0);
        chk("post_rst_run", 64'(cpu_run), 64'd0);
        chk("post_rst_err", 64'(err), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
